seg_scan_ctrl: RTL and testbench

Time-multiplexed scan controller for the board's 6-digit common-select seven-segment display. It holds one frame of six hex nibbles plus a per-digit blank mask and sequences the digits one at a time, with a dwell period and an anti-ghosting blank gap between digits. A valid/ready update port accepts new frame content at any time, but the content is applied only at a frame boundary, so a displayed frame never mixes old and new digits. It drives the disp/dig pins directly and replaces the direct nibble-to-segment connection used for state display.

---
 rtl/seg_pkg.sv | 18 +
 rtl/seg_hex_decode.sv | 11 +
 rtl/seg_scan_ctrl.sv | 100 ++++++++++
 tb/tb_seg_scan_ctrl.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared definitions for the seven-segment scan path: scan states and the
// active-low {g,f,e,d,c,b,a} hex glyph table.
package seg_pkg;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } scan_state_t;

    localparam logic [6:0] SEG_OFF = 7'h7F;

    // Index is the nibble value; 0 in a bit lights that segment.
    localparam logic [6:0] HEX_SEG [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

endpackage

// File: rtl/seg_hex_decode.sv
// Nibble to active-low seven-segment glyph, purely combinational.
module seg_hex_decode
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = HEX_SEG[nibble];

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed scan of a DIGITS-wide seven-segment display with dwell and
// blank-gap timing; frame updates are double-buffered and applied only at the wrap.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int DIGITS       = 6,
    parameter int DWELL_CYCLES = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  upd_valid,
    output logic                  upd_ready,
    input  logic [4*DIGITS-1:0]   upd_data,
    input  logic [DIGITS-1:0]     upd_blank,
    output logic [6:0]            disp,
    output logic [DIGITS-1:0]     dig,
    output logic                  frame_start
);

    localparam int CNT_MAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int IDX_W   = $clog2(DIGITS);

    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(DIGITS - 1);

    scan_state_t          state;
    logic [IDX_W-1:0]     idx;
    logic [CNT_W-1:0]     cnt;
    logic [4*DIGITS-1:0]  active_data;
    logic [DIGITS-1:0]    active_blank;
    logic [4*DIGITS-1:0]  pend_data;
    logic [DIGITS-1:0]    pend_blank;
    logic                 pend_valid;
    logic [6:0]           glyph;
    logic                 wrap;

    seg_hex_decode u_dec (
        .nibble (active_data[{idx, 2'b00} +: 4]),
        .seg    (glyph)
    );

    assign upd_ready = ~pend_valid;
    // Last edge of the last digit's dwell: every digit is dark afterwards.
    assign wrap = (state == ST_SHOW) && (cnt == DWELL_LAST) && (idx == IDX_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= ST_BLANK;
            idx          <= '0;
            cnt          <= '0;
            active_data  <= '0;
            active_blank <= '1;
            pend_data    <= '0;
            pend_blank   <= '0;
            pend_valid   <= 1'b0;
            disp         <= SEG_OFF;
            dig          <= '1;
            frame_start  <= 1'b0;
        end else begin
            frame_start <= 1'b0;
            if (state == ST_BLANK) begin
                if (cnt == BLANK_LAST) begin
                    state       <= ST_SHOW;
                    cnt         <= '0;
                    dig         <= ~(DIGITS'(1) << idx);
                    disp        <= active_blank[idx] ? SEG_OFF : glyph;
                    frame_start <= (idx == '0);
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                if (cnt == DWELL_LAST) begin
                    state <= ST_BLANK;
                    cnt   <= '0;
                    dig   <= '1;
                    disp  <= SEG_OFF;
                    idx   <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end

            // A capture is only possible with pend_valid low, so it never
            // coincides with a commit of the same payload.
            if (upd_valid && !pend_valid) begin
                pend_data  <= upd_data;
                pend_blank <= upd_blank;
                pend_valid <= 1'b1;
            end else if (wrap && pend_valid) begin
                active_data  <= pend_data;
                active_blank <= pend_blank;
                pend_valid   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with a short 2-cycle blank / 4-cycle dwell scan.
module tb_seg_scan_ctrl;

    localparam logic [6:0] HEX_TAB [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    logic        clk;
    logic        reset;
    logic        upd_valid;
    logic        upd_ready;
    logic [23:0] upd_data;
    logic [5:0]  upd_blank;
    logic [6:0]  disp;
    logic [5:0]  dig;
    logic        frame_start;

    int checks = 0;
    int errors = 0;
    int t = 0;
    logic [23:0] exp_data;
    logic [5:0]  exp_blank;

    seg_scan_ctrl #(.DIGITS(6), .DWELL_CYCLES(4), .BLANK_CYCLES(2)) dut (
        .clk         (clk),
        .reset       (reset),
        .upd_valid   (upd_valid),
        .upd_ready   (upd_ready),
        .upd_data    (upd_data),
        .upd_blank   (upd_blank),
        .disp        (disp),
        .dig         (dig),
        .frame_start (frame_start)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s t=%0d got=%h exp=%h", tag, t, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        t++;
    endtask

    // One cycle of scan checking against the expected active frame.
    // t counts edges since reset release; digit 0 is entered on edge 2.
    task automatic cyc();
        int u, w, s;
        logic [5:0] edig;
        logic [6:0] edisp;
        logic       efs;
        step();
        edig  = 6'h3F;
        edisp = 7'h7F;
        efs   = 1'b0;
        if (t >= 2) begin
            u = t - 2;
            w = u % 6;
            s = (u / 6) % 6;
            if (w < 4) begin
                edig[s] = 1'b0;
                if (!exp_blank[s]) edisp = HEX_TAB[exp_data[4*s +: 4]];
            end
            efs = (u % 36 == 0);
        end
        check("dig", 32'(dig), 32'(edig));
        check("disp", 32'(disp), 32'(edisp));
        check("frame_start", 32'(frame_start), 32'(efs));
    endtask

    task automatic run_to(input int tend);
        while (t < tend) cyc();
    endtask

    task automatic offer(input logic [23:0] d, input logic [5:0] b);
        upd_valid = 1'b1;
        upd_data  = d;
        upd_blank = b;
    endtask

    initial begin
        logic [23:0] dk;
        reset     = 1'b0;
        upd_valid = 1'b1;
        upd_data  = 24'h123456;
        upd_blank = 6'h00;
        exp_data  = 24'h0;
        exp_blank = 6'h3F;

        // reset state while upd_valid is asserted
        repeat (3) @(posedge clk);
        #1;
        check("rst_disp", 32'(disp), 32'h7F);
        check("rst_dig", 32'(dig), 32'h3F);
        check("rst_ready", 32'(upd_ready), 32'h1);
        check("rst_fs", 32'(frame_start), 32'h0);
        upd_valid = 1'b0;
        reset     = 1'b1;
        t         = 0;

        // first frame: digits selected but dark
        run_to(2);
        offer(24'h543210, 6'h00);
        run_to(3);
        check("ready_after_xfer1", 32'(upd_ready), 32'h0);
        upd_valid = 1'b0;
        run_to(36);
        exp_data  = 24'h543210;
        exp_blank = 6'h00;
        check("ready_after_commit1", 32'(upd_ready), 32'h1);

        // update while digit 2 is lit; digits 2..5 keep old content
        run_to(50);
        offer(24'hFEDCBA, 6'h00);
        run_to(51);
        check("ready_mid_frame", 32'(upd_ready), 32'h0);
        upd_valid = 1'b0;
        run_to(72);
        exp_data = 24'hFEDCBA;
        check("ready_after_commit2", 32'(upd_ready), 32'h1);
        run_to(74);
        check("digit0_new_A", 32'(disp), 32'h08);

        // back-pressure: second payload held until ready returns
        offer(24'h0F1E2D, 6'h00);
        run_to(75);
        check("ready_bp_first", 32'(upd_ready), 32'h0);
        upd_data  = 24'h778899;
        upd_blank = 6'b000101;
        run_to(108);
        exp_data  = 24'h0F1E2D;
        exp_blank = 6'h00;
        check("ready_bp_commit", 32'(upd_ready), 32'h1);
        run_to(109);
        check("ready_bp_second", 32'(upd_ready), 32'h0);
        upd_valid = 1'b0;
        run_to(144);
        exp_data  = 24'h778899;
        exp_blank = 6'b000101;

        // every nibble value through digit 1
        for (int k = 0; k < 16; k++) begin
            dk = 24'h3C5A06;
            dk[7:4] = 4'(k);
            run_to(146 + 36 * k);
            offer(dk, 6'h00);
            run_to(147 + 36 * k);
            upd_valid = 1'b0;
            run_to(180 + 36 * k);
            exp_data  = dk;
            exp_blank = 6'h00;
        end

        // reset while digit 0 is lit and an update is pending
        run_to(722);
        offer(24'h888888, 6'h00);
        run_to(723);
        upd_valid = 1'b0;
        check("ready_pending", 32'(upd_ready), 32'h0);
        run_to(724);
        check("pre_rst_dig", 32'(dig), 32'h3E);
        reset = 1'b0;
        #1;
        check("midrst_disp", 32'(disp), 32'h7F);
        check("midrst_dig", 32'(dig), 32'h3F);
        check("midrst_ready", 32'(upd_ready), 32'h1);
        @(posedge clk);
        #1;
        reset     = 1'b1;
        t         = 0;
        exp_data  = 24'h0;
        exp_blank = 6'h3F;
        check("post_rst_ready", 32'(upd_ready), 32'h1);
        run_to(74);
        check("post_rst_ready_end", 32'(upd_ready), 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
